// File: rtl/ldr_mem_responder.sv
// ldr_mem_responder: packs loader byte writes into big-endian 16-bit SDRAM word writes
// and returns the 4-phase ldr_ack handshake to the HPS loader.
module ldr_mem_responder #(
    parameter int LAW = 20,
    parameter int MAW = 23,
    parameter logic [MAW-1:0] BASE = 23'h7F0000
) (
    input  logic           sysclk,
    input  logic           rstn,
    input  logic [LAW-1:0] ldr_addr,
    input  logic [7:0]     ldr_wdat,
    input  logic           ldr_aen,
    input  logic           ldr_wr,
    output logic           ldr_ack,
    output logic           mem_req,
    output logic [MAW-1:0] mem_addr,
    output logic [15:0]    mem_wdat,
    output logic [1:0]     mem_be,
    input  logic           mem_ack,
    output logic           busy,
    output logic [19:0]    wcount
);
    typedef enum logic [2:0] {IDLE, EVAL, MEMW, FLUSHW, ACK, DROP} state_t;
    state_t state, state_n;
    logic [LAW-2:0] a_wa, a_wa_n, pwa, pwa_n;
    logic [7:0] a_dat, a_dat_n, hi, hi_n;
    logic a_odd, a_odd_n, pend, pend_n, aen_q, fl_idle, fl_idle_n;
    logic ack_n, req_n, match;
    logic [MAW-1:0] addr_n;
    logic [15:0] wdat_n;
    logic [1:0] be_n;
    logic [19:0] wcount_n;

    function automatic logic [MAW-1:0] wmap(input logic [LAW-2:0] wa);
        return BASE + MAW'(wa);
    endfunction

    assign match = pend && (pwa == a_wa);
    assign busy = (state != IDLE) || pend;

    always_comb begin
        state_n = state;
        a_wa_n = a_wa;
        a_odd_n = a_odd;
        a_dat_n = a_dat;
        pend_n = pend;
        hi_n = hi;
        pwa_n = pwa;
        fl_idle_n = fl_idle;
        ack_n = ldr_ack;
        req_n = mem_req;
        addr_n = mem_addr;
        wdat_n = mem_wdat;
        be_n = mem_be;
        wcount_n = wcount;
        case (state)
            IDLE: begin
                // a pending high byte left behind when the download window closed
                if (pend && !aen_q) begin
                    req_n = 1'b1;
                    addr_n = wmap(pwa);
                    wdat_n = {hi, 8'h00};
                    be_n = 2'b10;
                    fl_idle_n = 1'b1;
                    state_n = FLUSHW;
                end else if (ldr_aen && ldr_wr) begin
                    a_wa_n = ldr_addr[LAW-1:1];
                    a_odd_n = ldr_addr[0];
                    a_dat_n = ldr_wdat;
                    state_n = EVAL;
                end
            end
            EVAL: begin
                if (pend && !match) begin
                    req_n = 1'b1;
                    addr_n = wmap(pwa);
                    wdat_n = {hi, 8'h00};
                    be_n = 2'b10;
                    state_n = FLUSHW;
                end else if (!a_odd) begin
                    hi_n = a_dat;
                    pend_n = 1'b1;
                    pwa_n = a_wa;
                    state_n = ACK;
                end else begin
                    req_n = 1'b1;
                    addr_n = wmap(a_wa);
                    wdat_n = {match ? hi : 8'h00, a_dat};
                    be_n = {match, 1'b1};
                    pend_n = 1'b0;
                    state_n = MEMW;
                end
            end
            MEMW: begin
                if (mem_ack) begin
                    req_n = 1'b0;
                    wcount_n = wcount + 20'd1;
                    state_n = ACK;
                end
            end
            FLUSHW: begin
                // after a flush, re-evaluate the held byte with pend now clear
                if (mem_ack) begin
                    req_n = 1'b0;
                    wcount_n = wcount + 20'd1;
                    pend_n = 1'b0;
                    fl_idle_n = 1'b0;
                    state_n = fl_idle ? IDLE : EVAL;
                end
            end
            ACK: begin
                ack_n = 1'b1;
                state_n = DROP;
            end
            DROP: begin
                if (!ldr_wr) begin
                    ack_n = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            a_wa <= '0;
            a_odd <= 1'b0;
            a_dat <= '0;
            pend <= 1'b0;
            hi <= '0;
            pwa <= '0;
            aen_q <= 1'b0;
            fl_idle <= 1'b0;
            ldr_ack <= 1'b0;
            mem_req <= 1'b0;
            mem_addr <= '0;
            mem_wdat <= '0;
            mem_be <= '0;
            wcount <= '0;
        end else begin
            state <= state_n;
            a_wa <= a_wa_n;
            a_odd <= a_odd_n;
            a_dat <= a_dat_n;
            pend <= pend_n;
            hi <= hi_n;
            pwa <= pwa_n;
            aen_q <= ldr_aen;
            fl_idle <= fl_idle_n;
            ldr_ack <= ack_n;
            mem_req <= req_n;
            mem_addr <= addr_n;
            mem_wdat <= wdat_n;
            mem_be <= be_n;
            wcount <= wcount_n;
        end
    end
endmodule

// File: tb/tb_ldr_mem_responder.sv
// tb_ldr_mem_responder: table-driven loader byte vectors plus directed slow-arbiter,
// spurious-ack and reset-mid-write sequences.
module tb_ldr_mem_responder;
    logic sysclk, rstn, ldr_aen, ldr_wr, ldr_ack, mem_req, busy, arb_ack, spur_ack;
    logic [19:0] ldr_addr, wcount;
    logic [7:0] ldr_wdat;
    logic [22:0] mem_addr;
    logic [15:0] mem_wdat;
    logic [1:0] mem_be;
    int checks = 0, failures = 0, ack_dly = 1, ack_rises = 0;
    logic ack_prev = 1'b0;
    logic [40:0] wlog[$];

    typedef struct {
        bit op;
        logic [19:0] addr;
        logic [7:0] dat;
        int nw;
        logic [40:0] w0;
        logic [40:0] w1;
        logic [19:0] wc;
        int lat;
    } vec_t;
    vec_t tbl[15];

    ldr_mem_responder dut (
        .sysclk(sysclk), .rstn(rstn), .ldr_addr(ldr_addr), .ldr_wdat(ldr_wdat),
        .ldr_aen(ldr_aen), .ldr_wr(ldr_wr), .ldr_ack(ldr_ack), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_wdat(mem_wdat), .mem_be(mem_be),
        .mem_ack(arb_ack | spur_ack), .busy(busy), .wcount(wcount)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    always @(negedge sysclk) begin
        if (ldr_ack && !ack_prev) ack_rises++;
        ack_prev = ldr_ack;
    end

    // arbiter model: acks after ack_dly cycles of mem_req and logs the word written
    initial begin
        int cnt = 0;
        arb_ack = 1'b0;
        forever begin
            @(posedge sysclk);
            #1;
            if (arb_ack) arb_ack = 1'b0;
            else if (mem_req) begin
                cnt++;
                if (cnt >= ack_dly) begin
                    wlog.push_back({mem_addr, mem_wdat, mem_be});
                    arb_ack = 1'b1;
                    cnt = 0;
                end
            end else cnt = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wr_byte(input logic [19:0] a, input logic [7:0] d, input int hold, output int lat);
        int n = 0;
        ldr_aen = 1'b1;
        ldr_addr = a;
        ldr_wdat = d;
        ldr_wr = 1'b1;
        do begin tick(); n++; end while (!ldr_ack && n < 200);
        if (!ldr_ack) chk("ack_rise_timeout", 0, 1);
        lat = n - 1;
        repeat (hold) begin tick(); chk("ack_hold", ldr_ack, 1); end
        ldr_wr = 1'b0;
        n = 0;
        do begin tick(); n++; end while (ldr_ack && n < 50);
        if (ldr_ack) chk("ack_fall_timeout", 1, 0);
    endtask

    initial begin
        int lat, n, r0, nreq, last;
        bit stable;
        tbl[0]  = '{0, 20'h00000, 8'h12, 0, 41'h0, 41'h0, 20'd0, 2};
        tbl[1]  = '{0, 20'h00001, 8'h34, 1, {23'h7F0000, 16'h1234, 2'b11}, 41'h0, 20'd1, 3};
        tbl[2]  = '{0, 20'h00004, 8'hAB, 0, 41'h0, 41'h0, 20'd1, 2};
        tbl[3]  = '{1, 20'h00000, 8'h00, 1, {23'h7F0002, 16'hAB00, 2'b10}, 41'h0, 20'd2, 0};
        tbl[4]  = '{0, 20'h00007, 8'h5C, 1, {23'h7F0003, 16'h005C, 2'b01}, 41'h0, 20'd3, 3};
        tbl[5]  = '{0, 20'h00010, 8'h11, 0, 41'h0, 41'h0, 20'd3, 2};
        tbl[6]  = '{0, 20'h00020, 8'h22, 1, {23'h7F0008, 16'h1100, 2'b10}, 41'h0, 20'd4, 4};
        tbl[7]  = '{1, 20'h00000, 8'h00, 1, {23'h7F0010, 16'h2200, 2'b10}, 41'h0, 20'd5, 0};
        tbl[8]  = '{0, 20'h00040, 8'h77, 0, 41'h0, 41'h0, 20'd5, 2};
        tbl[9]  = '{0, 20'h00040, 8'h88, 0, 41'h0, 41'h0, 20'd5, 2};
        tbl[10] = '{0, 20'h00041, 8'h99, 1, {23'h7F0020, 16'h8899, 2'b11}, 41'h0, 20'd6, 3};
        tbl[11] = '{0, 20'h00050, 8'h01, 0, 41'h0, 41'h0, 20'd6, 2};
        tbl[12] = '{0, 20'h00063, 8'h02, 2, {23'h7F0028, 16'h0100, 2'b10},
                    {23'h7F0031, 16'h0002, 2'b01}, 20'd8, 5};
        tbl[13] = '{0, 20'hFFFFF, 8'hE1, 1, {23'h06FFFF, 16'h00E1, 2'b01}, 41'h0, 20'd9, 3};
        tbl[14] = '{1, 20'h00000, 8'h00, 0, 41'h0, 41'h0, 20'd9, 0};
        rstn = 1'b0;
        ldr_aen = 1'b0;
        ldr_wr = 1'b0;
        ldr_addr = '0;
        ldr_wdat = '0;
        spur_ack = 1'b0;
        repeat (3) tick();
        chk("rst_outputs", {ldr_ack, mem_req, busy, mem_be}, 0);
        chk("rst_data", {mem_addr, mem_wdat, wcount}, 0);
        rstn = 1'b1;
        tick();
        foreach (tbl[i]) begin
            r0 = ack_rises;
            wlog.delete();
            lat = 0;
            if (tbl[i].op) begin
                ldr_aen = 1'b0;
                repeat (2) tick();
                n = 0;
                while (busy && n < 50) begin tick(); n++; end
                chk($sformatf("v%0d_idle", i), busy, 0);
            end else wr_byte(tbl[i].addr, tbl[i].dat, 0, lat);
            tick();
            chk($sformatf("v%0d_nwrites", i), wlog.size(), tbl[i].nw);
            if (tbl[i].nw > 0) chk($sformatf("v%0d_w0", i), wlog.size() > 0 ? wlog[0] : 41'h0, tbl[i].w0);
            if (tbl[i].nw > 1) chk($sformatf("v%0d_w1", i), wlog.size() > 1 ? wlog[1] : 41'h0, tbl[i].w1);
            chk($sformatf("v%0d_wcount", i), wcount, tbl[i].wc);
            chk($sformatf("v%0d_acks", i), ack_rises - r0, tbl[i].op ? 0 : 1);
            if (!tbl[i].op) chk($sformatf("v%0d_latency", i), lat, tbl[i].lat);
        end

        // slow arbiter: request held stable for 7 cycles, ack one cycle after mem_ack
        ack_dly = 7;
        wlog.delete();
        wr_byte(20'h00100, 8'hAA, 0, lat);
        ldr_addr = 20'h00101;
        ldr_wdat = 8'hBB;
        ldr_wr = 1'b1;
        n = 0;
        nreq = 0;
        last = 0;
        stable = 1'b1;
        while (n < 100 && !ldr_ack) begin
            tick();
            n++;
            if (mem_req) begin
                nreq++;
                last = n;
                if ({mem_addr, mem_wdat, mem_be} !== {23'h7F0080, 16'hAABB, 2'b11}) stable = 1'b0;
            end
        end
        chk("slow_req_cycles", nreq, 7);
        chk("slow_req_stable", stable, 1);
        chk("slow_ack_delay", n, last + 2);
        repeat (3) begin tick(); chk("slow_ack_held", ldr_ack, 1); end
        ldr_wr = 1'b0;
        n = 0;
        do begin tick(); n++; end while (ldr_ack && n < 50);
        chk("slow_ack_drop", ldr_ack, 0);
        chk("slow_write", wlog.size() > 0 ? wlog[0] : 41'h0, {23'h7F0080, 16'hAABB, 2'b11});
        chk("slow_wcount", wcount, 10);

        // stray mem_ack with no request outstanding
        ack_dly = 1;
        repeat (2) tick();
        spur_ack = 1'b1;
        tick();
        spur_ack = 1'b0;
        repeat (2) tick();
        chk("spur_wcount", wcount, 10);
        chk("spur_req", {mem_req, ldr_ack}, 0);

        // reset while a word write is outstanding
        ack_dly = 20;
        wr_byte(20'h00200, 8'h01, 0, lat);
        ldr_addr = 20'h00201;
        ldr_wdat = 8'h02;
        ldr_wr = 1'b1;
        n = 0;
        while (!mem_req && n < 20) begin tick(); n++; end
        chk("rstmid_req_seen", mem_req, 1);
        rstn = 1'b0;
        #1;
        chk("rstmid_req", mem_req, 0);
        chk("rstmid_ack", ldr_ack, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_wcount", wcount, 0);
        ldr_wr = 1'b0;
        repeat (2) tick();
        rstn = 1'b1;
        ack_dly = 1;
        tick();
        wlog.delete();
        wr_byte(20'h00300, 8'hC3, 0, lat);
        wr_byte(20'h00301, 8'hD4, 0, lat);
        tick();
        chk("post_rst_nwrites", wlog.size(), 1);
        chk("post_rst_write", wlog.size() > 0 ? wlog[0] : 41'h0, {23'h7F0180, 16'hC3D4, 2'b11});
        chk("post_rst_wcount", wcount, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
